pulse_sync_ack: RTL and testbench

- Acknowledged pulse/data synchronizer: carries a single-cycle event plus a DATA_W payload from the i_clk domain to the o_clk domain.
- Returns a toggle acknowledge to the source, so the source knows when the next event may be sent.
- Source side rejects and counts events offered while a transfer is in flight.
- Used wherever the unacknowledged toggle pulse synchronizer could silently lose back-to-back pulses.

---
 rtl/pulse_sync_ack.sv | 204 ++++++++++++++++++++
 tb/tb_pulse_sync_ack.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_ack.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pulse_sync_ack
//   Acknowledged pulse/data synchronizer. A single-cycle event plus a DATA_W
//   payload is carried from the i_clk domain to the o_clk domain using a
//   request toggle. A toggle acknowledge is returned to the source so that it
//   knows when the next event may be sent. Events offered while a transfer is
//   in flight are rejected and counted.
//
// Ports
//   i_clk, i_rst_n   source clock / async active-low reset
//   o_clk, o_rst_n   destination clock / async active-low reset
//   i_pulse          source event, one i_clk cycle per event
//   i_data           payload, sampled when i_pulse is accepted
//   i_busy           transfer in flight; a new i_pulse will be dropped
//   i_done           one-cycle pulse when the acknowledge returns
//   i_drop           one-cycle pulse when an i_pulse is rejected
//   i_drop_cnt       saturating count of rejected pulses
//   o_pulse          one-cycle pulse per accepted event (o_clk domain)
//   o_data           payload, updated on the o_pulse cycle and held
// -----------------------------------------------------------------------------
module pulse_sync_ack #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              o_clk,
   input  logic              o_rst_n,
   input  logic              i_pulse,
   input  logic [DATA_W-1:0] i_data,
   output logic              i_busy,
   output logic              i_done,
   output logic              i_drop,
   output logic [CNT_W-1:0]  i_drop_cnt,
   output logic              o_pulse,
   output logic [DATA_W-1:0] o_data
);

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } src_state_e;

   // ---------------------------------------------------------------------------
   // Source domain signals
   // ---------------------------------------------------------------------------
   src_state_e             state_q, state_d;
   logic                   req_t_q, req_t_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   done_q, done_d;
   logic                   drop_q, drop_d;
   logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_synced;
   logic                   ack_match;

   // ---------------------------------------------------------------------------
   // Destination domain signals
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] req_sync_q;
   logic                   req_synced;
   logic                   req_seen_q, req_seen_d;
   logic                   o_pulse_q, o_pulse_d;
   logic [DATA_W-1:0]      o_data_q, o_data_d;

   // ---------------------------------------------------------------------------
   // Source FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The returned acknowledge is req_seen, so it matches req_t once the
   // destination has consumed the current request.
   assign ack_synced = ack_sync_q[SYNC_STAGES-1];
   assign ack_match  = (ack_synced == req_t_q);

   // ---------------------------------------------------------------------------
   // Source FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (i_pulse) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (ack_match) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Source FSM: outputs / datapath next values
   // Acceptance looks only at the registered state, so a pulse arriving on the
   // cycle the acknowledge returns is still rejected.
   // ---------------------------------------------------------------------------
   always_comb begin
      req_t_d    = req_t_q;
      data_d     = data_q;
      done_d     = 1'b0;
      drop_d     = 1'b0;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_pulse) begin
               req_t_d = ~req_t_q;
               data_d  = i_data;
            end
         end
         S_BUSY: begin
            done_d = ack_match;
            if (i_pulse) begin
               drop_d = 1'b1;
               if (drop_cnt_q != '1) begin
                  drop_cnt_d = drop_cnt_q + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_t_q    <= 1'b0;
         data_q     <= '0;
         done_q     <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         req_t_q    <= req_t_d;
         data_q     <= data_d;
         done_q     <= done_d;
         drop_q     <= drop_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Acknowledge synchronizer into i_clk; req_seen_q leaves a flop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ack_sync_q <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], req_seen_q};
      end
   end

   assign i_busy     = (state_q == S_BUSY);
   assign i_done     = done_q;
   assign i_drop     = drop_q;
   assign i_drop_cnt = drop_cnt_q;

   // ---------------------------------------------------------------------------
   // Destination domain
   // data_q is captured directly: the source holds it stable from before the
   // request toggle leaves until the acknowledge has returned.
   // ---------------------------------------------------------------------------
   always_ff @(posedge o_clk or negedge o_rst_n) begin
      if (!o_rst_n) begin
         req_sync_q <= '0;
      end else begin
         req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_t_q};
      end
   end

   assign req_synced = req_sync_q[SYNC_STAGES-1];

   always_comb begin
      req_seen_d = req_synced;
      o_pulse_d  = req_synced ^ req_seen_q;
      o_data_d   = o_data_q;
      if (req_synced != req_seen_q) begin
         o_data_d = data_q;
      end
   end

   always_ff @(posedge o_clk or negedge o_rst_n) begin
      if (!o_rst_n) begin
         req_seen_q <= 1'b0;
         o_pulse_q  <= 1'b0;
         o_data_q   <= '0;
      end else begin
         req_seen_q <= req_seen_d;
         o_pulse_q  <= o_pulse_d;
         o_data_q   <= o_data_d;
      end
   end

   assign o_pulse = o_pulse_q;
   assign o_data  = o_data_q;

endmodule

// File: tb/tb_pulse_sync_ack.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pulse_sync_ack
//   Randomized and directed stimulus for pulse_sync_ack, checked against a
//   transaction-level model: a busy flag, a saturating drop count, a toggle
//   parity and a queue of payloads expected at the destination.
// -----------------------------------------------------------------------------
module tb_pulse_sync_ack;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

   logic              i_clk   = 1'b0;
   logic              o_clk   = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              o_rst_n = 1'b0;
   logic              i_pulse = 1'b0;
   logic [DATA_W-1:0] i_data  = '0;
   logic              i_busy;
   logic              i_done;
   logic              i_drop;
   logic [CNT_W-1:0]  i_drop_cnt;
   logic              o_pulse;
   logic [DATA_W-1:0] o_data;

   realtime o_half = 13.5;

   pulse_sync_ack #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .o_clk      (o_clk),
      .o_rst_n    (o_rst_n),
      .i_pulse    (i_pulse),
      .i_data     (i_data),
      .i_busy     (i_busy),
      .i_done     (i_done),
      .i_drop     (i_drop),
      .i_drop_cnt (i_drop_cnt),
      .o_pulse    (o_pulse),
      .o_data     (o_data)
   );

   always #5 i_clk = ~i_clk;
   initial forever #(o_half) o_clk = ~o_clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] exp_q[$];
   logic              m_busy  = 1'b0;
   logic              m_par   = 1'b0;
   logic              in_rst  = 1'b0;
   int unsigned       m_cnt   = 0;
   int unsigned       m_age   = 0;
   int unsigned       n_done  = 0;
   int unsigned       n_drop  = 0;
   int unsigned       n_opulse = 0;
   logic [DATA_W-1:0] m_last  = '0;
   logic              p_s;
   logic [DATA_W-1:0] d_s;
   logic              mb, mdrop, macc;

   // Source side: inputs are captured at the active edge, outputs checked at
   // the following falling edge.
   always begin
      @(posedge i_clk);
      p_s = i_pulse;
      d_s = i_data;
      @(negedge i_clk);
      if (!i_rst_n) begin
         // A toggle left at 1 is seen by the destination as one more event
         // carrying the cleared payload.
         if (!in_rst && m_par) exp_q.push_back('0);
         in_rst = 1'b1;
         m_busy = 1'b0;
         m_par  = 1'b0;
         m_cnt  = 0;
         check_eq("rst_busy", i_busy, 0);
         check_eq("rst_done", i_done, 0);
         check_eq("rst_drop", i_drop, 0);
         check_eq("rst_cnt", i_drop_cnt, 0);
      end else begin
         in_rst = 1'b0;
         mb     = m_busy;
         mdrop  = p_s & mb;
         macc   = p_s & ~mb;
         if (mb) m_age++;
         if (mdrop) begin
            n_drop++;
            if (m_cnt < CNT_MAX) m_cnt++;
         end
         if (i_done) begin
            check_eq("done_while_busy", mb, 1);
            check_eq("done_min_latency", (m_age >= SYNC_STAGES + 1), 1);
            m_busy = 1'b0;
            n_done++;
         end
         if (macc) begin
            m_busy = 1'b1;
            m_par  = ~m_par;
            m_age  = 0;
            exp_q.push_back(d_s);
         end
         if (m_busy) check_eq("busy_bound", (m_age <= 1000), 1);
         check_eq("i_busy", i_busy, m_busy);
         check_eq("i_drop", i_drop, mdrop);
         check_eq("i_drop_cnt", i_drop_cnt, m_cnt);
      end
   end

   // Destination side: every pulse must match the oldest outstanding payload
   // and o_data must hold between pulses.
   always @(negedge o_clk) begin
      if (!o_rst_n) begin
         m_last = '0;
      end else if (o_pulse) begin
         n_opulse++;
         check_eq("o_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            m_last = exp_q.pop_front();
            check_eq("o_data", o_data, m_last);
         end
      end else begin
         check_eq("o_hold", o_data, m_last);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic send(input logic [DATA_W-1:0] d);
      @(negedge i_clk);
      i_pulse = 1'b1;
      i_data  = d;
      @(negedge i_clk);
      i_pulse = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic seen = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge i_clk);
         if (i_done) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq(tag, seen, 1);
   endtask

   task automatic wait_idle(input string tag);
      logic idle = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge i_clk);
         if (!i_busy) begin
            idle = 1'b1;
            break;
         end
      end
      check_eq(tag, idle, 1);
   endtask

   int unsigned n0, d0, dr0, len, gap;
   logic        seen;
   realtime     halves[3] = '{1.25, 13.5, 20.0};

   initial begin
      // Reset
      repeat (3) @(negedge i_clk);
      check_eq("rst_o_pulse", o_pulse, 0);
      check_eq("rst_o_data", o_data, 0);
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b1;
      o_rst_n = 1'b1;
      repeat (5) @(negedge i_clk);

      // Single event, 100 MHz / ~37 MHz
      n0 = n_opulse; d0 = n_done;
      send(8'hA5);
      wait_done("single_done");
      repeat (20) @(negedge i_clk);
      check_eq("single_opulse", n_opulse - n0, 1);
      check_eq("single_odata", o_data, 8'hA5);
      check_eq("single_ndone", n_done - d0, 1);

      // Back-to-back pulses
      n0 = n_opulse; dr0 = n_drop;
      @(negedge i_clk); i_pulse = 1'b1; i_data = 8'h11;
      @(negedge i_clk); i_data = 8'h22;
      @(negedge i_clk); i_pulse = 1'b0;
      wait_done("b2b_done");
      repeat (20) @(negedge i_clk);
      check_eq("b2b_opulse", n_opulse - n0, 1);
      check_eq("b2b_odata", o_data, 8'h11);
      check_eq("b2b_ndrop", n_drop - dr0, 1);
      check_eq("b2b_cnt", i_drop_cnt, 1);

      // Ten events each after i_done, o_clk 4x faster then 4x slower
      for (int s = 0; s < 2; s++) begin
         o_half = (s == 0) ? 1.25 : 20.0;
         repeat (10) @(negedge i_clk);
         n0 = n_opulse;
         for (int i = 0; i < 10; i++) begin
            send(i[DATA_W-1:0]);
            wait_done("ten_done");
         end
         repeat (30) @(negedge i_clk);
         check_eq("ten_opulse", n_opulse - n0, 10);
         check_eq("ten_last", o_data, 9);
         check_eq("ten_cnt", i_drop_cnt, 1);
      end

      // Randomized events with random hold lengths and gaps
      for (int r = 0; r < 3; r++) begin
         o_half = halves[r];
         repeat (10) @(negedge i_clk);
         for (int e = 0; e < 10; e++) begin
            len = $urandom_range(4, 1);
            gap = $urandom_range(25, 0);
            for (int c = 0; c < int'(len); c++) begin
               @(negedge i_clk);
               i_pulse = 1'b1;
               i_data  = DATA_W'($urandom);
            end
            @(negedge i_clk);
            i_pulse = 1'b0;
            repeat (gap) @(negedge i_clk);
         end
         wait_idle("rand_idle");
         repeat (30) @(negedge i_clk);
      end

      // Drop counter saturation: pulse held 20 cycles after an accept
      o_half = 20.0;
      repeat (5) @(negedge i_clk);
      @(negedge i_clk); i_pulse = 1'b1; i_data = 8'h55;
      repeat (20) @(negedge i_clk);
      i_pulse = 1'b0;
      wait_idle("sat_idle");
      repeat (30) @(negedge i_clk);
      check_eq("sat_cnt", i_drop_cnt, CNT_MAX);

      // Pulse coincident with the acknowledge-return cycle
      o_half = 13.5;
      repeat (5) @(negedge i_clk);
      seen = 1'b0;
      @(negedge i_clk); i_pulse = 1'b1; i_data = 8'h66;
      for (int k = 0; k < 1000; k++) begin
         @(negedge i_clk);
         if (i_done) begin
            seen = 1'b1;
            check_eq("coinc_drop", i_drop, 1);
            break;
         end
      end
      i_pulse = 1'b0;
      check_eq("coinc_seen", seen, 1);
      repeat (20) @(negedge i_clk);

      // Source reset after a completed transfer that left req_t at 1
      if (!m_par) begin
         send(8'h77);
         wait_done("par_done");
      end
      repeat (20) @(negedge i_clk);
      n0 = n_opulse; d0 = n_done;
      @(posedge i_clk); #2; i_rst_n = 1'b0;
      repeat (3) @(posedge i_clk);
      #2; i_rst_n = 1'b1;
      repeat (60) @(negedge i_clk);
      check_eq("rst_phantom_n", n_opulse - n0, 1);
      check_eq("rst_phantom_data", o_data, 0);
      check_eq("rst_src_idle", i_busy, 0);
      check_eq("rst_cnt_clear", i_drop_cnt, 0);
      check_eq("rst_no_done", n_done - d0, 0);
      send(8'h3C);
      wait_done("post_rst_done");
      repeat (20) @(negedge i_clk);
      check_eq("post_rst_data", o_data, 8'h3C);

      check_eq("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached (%0d run, %0d failed)", n_tests, n_fail);
      $fatal(1);
   end

endmodule
